// File: rtl/bp_me_nonsynth_mock_cce.sv
// Mock CCE: answers one LCE at a time with fill/uncached commands and tracks completed
// transactions plus a sticky protocol-error flag. Message layouts live in the package below.
package bp_me_mock_cce_pkg;
  typedef enum logic [1:0] {e_bp_unicore_half_cfg, e_bp_unicore_cfg} bp_params_e;

  typedef struct packed {
    int paddr_width;
    int lce_id_width;
    int cce_id_width;
    int lce_assoc;
    int cce_block_width;
  } bp_proc_param_s;

  localparam logic [3:0] e_bedrock_req_rd_miss      = 4'd0;
  localparam logic [3:0] e_bedrock_req_wr_miss      = 4'd1;
  localparam logic [3:0] e_bedrock_req_uc_rd        = 4'd2;
  localparam logic [3:0] e_bedrock_req_uc_wr        = 4'd3;
  localparam logic [3:0] e_bedrock_cmd_data         = 4'd4;
  localparam logic [3:0] e_bedrock_cmd_uc_data      = 4'd11;
  localparam logic [3:0] e_bedrock_cmd_uc_req_done  = 4'd12;
  localparam logic [3:0] e_bedrock_resp_coh_ack     = 4'd2;
  localparam logic [2:0] e_coh_i = 3'd0;
  localparam logic [2:0] e_coh_s = 3'd1;
  localparam logic [2:0] e_coh_e = 3'd2;
  localparam logic [2:0] e_coh_m = 3'd6;

  function automatic bp_proc_param_s bp_get_proc_param(bp_params_e cfg);
    bp_proc_param_s p;
    case (cfg)
      e_bp_unicore_cfg: p = '{paddr_width: 40, lce_id_width: 4, cce_id_width: 4,
                              lce_assoc: 8, cce_block_width: 512};
      default:          p = '{paddr_width: 40, lce_id_width: 4, cce_id_width: 4,
                              lce_assoc: 4, cce_block_width: 256};
    endcase
    return p;
  endfunction

  // req:  {data[64], lru_way, non_exclusive, size[3], addr, src_id, msg_type[4]}
  function automatic int lce_req_msg_width(bp_params_e cfg);
    bp_proc_param_s p = bp_get_proc_param(cfg);
    return 4 + p.lce_id_width + p.paddr_width + 3 + 1 + $clog2(p.lce_assoc) + 64;
  endfunction

  // cmd:  {data[block], target_way, target, state[3], way, size[3], addr, src_id, dst_id, msg_type[4]}
  function automatic int lce_cmd_msg_width(bp_params_e cfg);
    bp_proc_param_s p = bp_get_proc_param(cfg);
    return 4 + 2 * p.lce_id_width + p.cce_id_width + p.paddr_width + 6
           + 2 * $clog2(p.lce_assoc) + p.cce_block_width;
  endfunction

  // resp: {addr, src_id, msg_type[4]}
  function automatic int lce_resp_msg_width(bp_params_e cfg);
    bp_proc_param_s p = bp_get_proc_param(cfg);
    return 4 + p.lce_id_width + p.paddr_width;
  endfunction
endpackage

// state   | meaning
// e_ready | waiting for an LCE request
// e_cmd   | command presented, waiting for yumi
// e_ack   | fill sent, waiting for the LCE coh_ack
module bp_me_nonsynth_mock_cce
  import bp_me_mock_cce_pkg::*;
  #(parameter bp_params_e bp_params_p = e_bp_unicore_half_cfg
  , parameter int cce_id_p = 0
  , parameter int txn_count_width_p = 16
  , localparam bp_proc_param_s proc_lp = bp_get_proc_param(bp_params_p)
  , localparam int paddr_width_p = proc_lp.paddr_width
  , localparam int lce_id_width_p = proc_lp.lce_id_width
  , localparam int cce_id_width_p = proc_lp.cce_id_width
  , localparam int lce_assoc_p = proc_lp.lce_assoc
  , localparam int cce_block_width_p = proc_lp.cce_block_width
  , localparam int lce_req_msg_width_lp = lce_req_msg_width(bp_params_p)
  , localparam int lce_cmd_msg_width_lp = lce_cmd_msg_width(bp_params_p)
  , localparam int lce_resp_msg_width_lp = lce_resp_msg_width(bp_params_p)
  )
  (input  logic                             clk_i
  , input  logic                            reset_n_i
  , input  logic [lce_req_msg_width_lp-1:0] lce_req_i
  , input  logic                            lce_req_v_i
  , output logic                            lce_req_ready_then_o
  , output logic [lce_cmd_msg_width_lp-1:0] lce_cmd_o
  , output logic                            lce_cmd_v_o
  , input  logic                            lce_cmd_yumi_i
  , input  logic [lce_resp_msg_width_lp-1:0] lce_resp_i
  , input  logic                            lce_resp_v_i
  , output logic                            lce_resp_yumi_o
  , output logic [txn_count_width_p-1:0]    txn_count_o
  , output logic                            error_o
  );

  localparam int way_w = $clog2(lce_assoc_p);
  localparam int blk_off_w = $clog2(cce_block_width_p / 8);
  localparam int dwords_lp = cce_block_width_p / 64;
  localparam logic [cce_id_width_p-1:0] cce_id_lp = cce_id_width_p'(cce_id_p);

  typedef enum logic [1:0] {e_ready, e_cmd, e_ack} state_e;
  state_e state_r, state_n;

  logic [63:0]                in_data;
  logic [way_w-1:0]           in_way;
  logic                       in_ne;
  logic [2:0]                 in_size;
  logic [paddr_width_p-1:0]   in_addr;
  logic [lce_id_width_p-1:0]  in_src;
  logic [3:0]                 in_type;
  assign {in_data, in_way, in_ne, in_size, in_addr, in_src, in_type} = lce_req_i;

  logic [paddr_width_p-1:0]   resp_addr;
  logic [lce_id_width_p-1:0]  resp_src;
  logic [3:0]                 resp_type;
  assign {resp_addr, resp_src, resp_type} = lce_resp_i;

  logic [63:0]                req_data_r;
  logic [way_w-1:0]           req_way_r;
  logic                       req_ne_r;
  logic [2:0]                 req_size_r;
  logic [paddr_width_p-1:0]   req_addr_r;
  logic [lce_id_width_p-1:0]  req_src_r;
  logic [3:0]                 req_type_r;
  logic [txn_count_width_p-1:0] txn_count_r;
  logic error_r, out_of_reset_r;
  logic req_accept, count_inc, err_set;

  // The request payload is captured with the header but no command carries it back.
  logic [63:0] req_data_unused;
  assign req_data_unused = req_data_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= e_ready;
    else            state_r <= state_n;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      out_of_reset_r <= 1'b0;
      {req_data_r, req_way_r, req_ne_r, req_size_r, req_addr_r, req_src_r, req_type_r} <= '0;
      txn_count_r <= '0;
      error_r <= 1'b0;
    end else begin
      out_of_reset_r <= 1'b1;
      if (req_accept)
        {req_data_r, req_way_r, req_ne_r, req_size_r, req_addr_r, req_src_r, req_type_r}
          <= lce_req_i;
      if (count_inc) txn_count_r <= txn_count_r + txn_count_width_p'(1);
      if (err_set) error_r <= 1'b1;
    end
  end

  always_comb begin
    state_n = state_r;
    req_accept = 1'b0;
    count_inc = 1'b0;
    err_set = 1'b0;
    lce_req_ready_then_o = 1'b0;
    lce_cmd_v_o = 1'b0;
    lce_resp_yumi_o = 1'b0;
    case (state_r)
      e_ready: begin
        lce_req_ready_then_o = out_of_reset_r;
        if (out_of_reset_r && lce_req_v_i) begin
          req_accept = 1'b1;
          if (in_type <= e_bedrock_req_uc_wr) state_n = e_cmd;
          else                                err_set = 1'b1;
        end
      end
      e_cmd: begin
        lce_cmd_v_o = 1'b1;
        if (lce_cmd_yumi_i) begin
          if (req_type_r == e_bedrock_req_rd_miss || req_type_r == e_bedrock_req_wr_miss)
            state_n = e_ack;
          else begin
            state_n = e_ready;
            count_inc = 1'b1;
          end
        end
      end
      e_ack: begin
        lce_resp_yumi_o = lce_resp_v_i;
        if (lce_resp_v_i) begin
          if (resp_type == e_bedrock_resp_coh_ack && resp_addr == req_addr_r
              && resp_src == req_src_r) begin
            state_n = e_ready;
            count_inc = 1'b1;
          end else
            err_set = 1'b1;
        end
      end
      default: state_n = e_ready;
    endcase
  end

  logic [63:0] fill_base;
  logic [cce_block_width_p-1:0] fill, cmd_data;
  logic [3:0] cmd_type;
  logic [2:0] cmd_state;
  assign fill_base = 64'({req_addr_r[paddr_width_p-1:blk_off_w], blk_off_w'(0)});

  always_comb begin
    fill = '0;
    for (int k = 0; k < dwords_lp; k++) fill[k*64 +: 64] = fill_base + 64'(k);
  end

  always_comb begin
    cmd_type = e_bedrock_cmd_uc_req_done;
    cmd_state = e_coh_i;
    cmd_data = '0;
    case (req_type_r)
      e_bedrock_req_rd_miss: begin
        cmd_type = e_bedrock_cmd_data;
        cmd_state = req_ne_r ? e_coh_s : e_coh_e;
        cmd_data = fill;
      end
      e_bedrock_req_wr_miss: begin
        cmd_type = e_bedrock_cmd_data;
        cmd_state = e_coh_m;
        cmd_data = fill;
      end
      e_bedrock_req_uc_rd: begin
        cmd_type = e_bedrock_cmd_uc_data;
        cmd_data = fill;
      end
      default: ;
    endcase
  end

  assign lce_cmd_o = {cmd_data, {way_w{1'b0}}, {lce_id_width_p{1'b0}}, cmd_state, req_way_r,
                      req_size_r, req_addr_r, cce_id_lp, req_src_r, cmd_type};
  assign txn_count_o = txn_count_r;
  assign error_o = error_r;

endmodule

// File: tb/tb_bp_me_nonsynth_mock_cce.sv
// Bench for the mock CCE: directed protocol scenarios plus randomized transactions checked
// against a transaction-level model of the expected commands and counters.
module tb_bp_me_nonsynth_mock_cce;
  import bp_me_mock_cce_pkg::*;

  localparam bp_params_e CFG = e_bp_unicore_half_cfg;
  localparam bp_proc_param_s P = bp_get_proc_param(CFG);
  localparam int PA = P.paddr_width;
  localparam int LI = P.lce_id_width;
  localparam int CI = P.cce_id_width;
  localparam int WW = $clog2(P.lce_assoc);
  localparam int BW = P.cce_block_width;
  localparam int DW = BW / 64;
  localparam int BLK_BYTES = BW / 8;
  localparam int REQ_W = lce_req_msg_width(CFG);
  localparam int CMD_W = lce_cmd_msg_width(CFG);
  localparam int RESP_W = lce_resp_msg_width(CFG);
  // Narrow counter so the wrap is reachable in a short run.
  localparam int CNT_W = 8;
  localparam int CCE_ID = 2;
  localparam logic [3:0] RESP_INV_ACK = 4'd1;

  logic clk, reset_n;
  logic [REQ_W-1:0] lce_req;
  logic lce_req_v, lce_req_ready_then;
  logic [CMD_W-1:0] lce_cmd;
  logic lce_cmd_v, lce_cmd_yumi;
  logic [RESP_W-1:0] lce_resp;
  logic lce_resp_v, lce_resp_yumi;
  logic [CNT_W-1:0] txn_count;
  logic error;

  bp_me_nonsynth_mock_cce #(.bp_params_p(CFG), .cce_id_p(CCE_ID), .txn_count_width_p(CNT_W)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .lce_req_i(lce_req), .lce_req_v_i(lce_req_v), .lce_req_ready_then_o(lce_req_ready_then),
    .lce_cmd_o(lce_cmd), .lce_cmd_v_o(lce_cmd_v), .lce_cmd_yumi_i(lce_cmd_yumi),
    .lce_resp_i(lce_resp), .lce_resp_v_i(lce_resp_v), .lce_resp_yumi_o(lce_resp_yumi),
    .txn_count_o(txn_count), .error_o(error));

  logic [BW-1:0] c_data;
  logic [WW-1:0] c_twy, c_way;
  logic [LI-1:0] c_tgt, c_dst;
  logic [2:0] c_state, c_size;
  logic [PA-1:0] c_addr;
  logic [CI-1:0] c_src;
  logic [3:0] c_type;
  assign {c_data, c_twy, c_tgt, c_state, c_way, c_size, c_addr, c_src, c_dst, c_type} = lce_cmd;

  int checks = 0;
  int failures = 0;
  int exp_count = 0;
  logic exp_error = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [REQ_W-1:0] mk_req(input logic [3:0] t, input logic [LI-1:0] src,
      input logic [PA-1:0] addr, input logic [2:0] size, input logic ne,
      input logic [WW-1:0] way, input logic [63:0] data);
    return {data, way, ne, size, addr, src, t};
  endfunction

  function automatic logic [RESP_W-1:0] mk_resp(input logic [3:0] t, input logic [LI-1:0] src,
      input logic [PA-1:0] addr);
    return {addr, src, t};
  endfunction

  function automatic bit is_miss(input logic [3:0] t);
    return t == e_bedrock_req_rd_miss || t == e_bedrock_req_wr_miss;
  endfunction

  function automatic logic [3:0] model_cmd_type(input logic [3:0] t);
    if (is_miss(t)) return e_bedrock_cmd_data;
    if (t == e_bedrock_req_uc_rd) return e_bedrock_cmd_uc_data;
    return e_bedrock_cmd_uc_req_done;
  endfunction

  function automatic logic [2:0] model_state(input logic [3:0] t, input logic ne);
    if (t == e_bedrock_req_wr_miss) return e_coh_m;
    return ne ? e_coh_s : e_coh_e;
  endfunction

  function automatic logic [63:0] model_dword(input logic [3:0] t, input logic [PA-1:0] addr,
      input int k);
    logic [63:0] a = 64'(addr);
    if (t == e_bedrock_req_uc_wr) return 64'd0;
    return (a / BLK_BYTES) * BLK_BYTES + 64'(k);
  endfunction

  task automatic send_req(input logic [3:0] t, input logic [LI-1:0] src, input logic [PA-1:0] addr,
      input logic [2:0] size, input logic ne, input logic [WW-1:0] way, input logic [63:0] data);
    int n = 0;
    @(negedge clk);
    lce_req = mk_req(t, src, addr, size, ne, way, data);
    lce_req_v = 1'b1;
    while (lce_req_ready_then !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", 64'(n < 20), 64'd1);
    @(posedge clk);
    #1 lce_req_v = 1'b0;
  endtask

  task automatic expect_cmd(input logic [3:0] t, input logic [LI-1:0] src, input logic [PA-1:0] addr,
      input logic [2:0] size, input logic ne, input logic [WW-1:0] way, input int hold,
      output int wait_cycles);
    int n = 0;
    @(negedge clk);
    while (lce_cmd_v !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    wait_cycles = n;
    check("cmd_v", 64'(lce_cmd_v), 64'd1);
    check("cmd_type", 64'(c_type), 64'(model_cmd_type(t)));
    check("cmd_dst", 64'(c_dst), 64'(src));
    check("cmd_src", 64'(c_src), 64'(CCE_ID));
    check("cmd_addr", 64'(c_addr), 64'(addr));
    check("cmd_way", 64'(c_way), 64'(way));
    check("cmd_target", 64'({c_tgt, c_twy}), 64'd0);
    if (is_miss(t)) check("cmd_state", 64'(c_state), 64'(model_state(t, ne)));
    if (t == e_bedrock_req_uc_rd) check("cmd_size", 64'(c_size), 64'(size));
    for (int k = 0; k < DW; k++)
      check($sformatf("cmd_dword%0d", k), c_data[k*64 +: 64], model_dword(t, addr, k));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_cmd_v", 64'(lce_cmd_v), 64'd1);
      check("hold_cmd_type", 64'(c_type), 64'(model_cmd_type(t)));
      check("hold_cmd_addr", 64'(c_addr), 64'(addr));
      check("hold_cmd_dword0", c_data[63:0], model_dword(t, addr, 0));
      if (is_miss(t)) check("hold_cmd_state", 64'(c_state), 64'(model_state(t, ne)));
    end
    lce_resp = mk_resp(e_bedrock_resp_coh_ack, src, addr);
    lce_resp_v = 1'b1;
    lce_cmd_yumi = 1'b1;
    #1 check("resp_yumi_outside_ack", 64'(lce_resp_yumi), 64'd0);
    @(posedge clk);
    #1 begin
      lce_cmd_yumi = 1'b0;
      lce_resp_v = 1'b0;
    end
  endtask

  task automatic send_resp(input logic [3:0] t, input logic [LI-1:0] src, input logic [PA-1:0] addr);
    @(negedge clk);
    lce_resp = mk_resp(t, src, addr);
    lce_resp_v = 1'b1;
    #1 check("resp_yumi_in_ack", 64'(lce_resp_yumi), 64'd1);
    @(posedge clk);
    #1 lce_resp_v = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_ready"}, 64'(lce_req_ready_then), 64'd1);
    check({tag, "_cmd_v"}, 64'(lce_cmd_v), 64'd0);
    check({tag, "_count"}, 64'(txn_count), 64'(exp_count));
    check({tag, "_error"}, 64'(error), 64'(exp_error));
  endtask

  task automatic do_txn(input logic [3:0] t, input logic [LI-1:0] src, input logic [PA-1:0] addr,
      input logic [2:0] size, input logic ne, input logic [WW-1:0] way, input int hold,
      input string tag);
    int w;
    send_req(t, src, addr, size, ne, way, {$urandom, $urandom});
    expect_cmd(t, src, addr, size, ne, way, hold, w);
    if (is_miss(t)) send_resp(e_bedrock_resp_coh_ack, src, addr);
    exp_count = (exp_count + 1) % (1 << CNT_W);
    check_idle(tag);
  endtask

  initial begin
    int w;
    logic [3:0] rt;
    reset_n = 1'b0;
    lce_req = '0;
    lce_req_v = 1'b0;
    lce_cmd_yumi = 1'b0;
    lce_resp = '0;
    lce_resp_v = 1'b0;

    #12;
    check("rst_ready", 64'(lce_req_ready_then), 64'd0);
    check("rst_cmd_v", 64'(lce_cmd_v), 64'd0);
    check("rst_resp_yumi", 64'(lce_resp_yumi), 64'd0);
    check("rst_count", 64'(txn_count), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("ready_before_edge", 64'(lce_req_ready_then), 64'd0);
    @(posedge clk);
    #1 check("ready_after_edge", 64'(lce_req_ready_then), 64'd1);

    // read miss, exclusive fill
    do_txn(e_bedrock_req_rd_miss, 4'd0, 40'h80_0000_40 >> 4, 3'd0, 1'b0, 2'd3, 0, "rd_miss");
    // write miss with yumi withheld for five cycles
    do_txn(e_bedrock_req_wr_miss, 4'd1, 40'h00_1234_5678, 3'd3, 1'b0, 2'd1, 5, "wr_miss_hold");

    // uncached write: done command within two cycles, no response needed
    send_req(e_bedrock_req_uc_wr, 4'd2, 40'h10, 3'd2, 1'b0, 2'd0, 64'hdead_beef);
    expect_cmd(e_bedrock_req_uc_wr, 4'd2, 40'h10, 3'd2, 1'b0, 2'd0, 0, w);
    check("uc_wr_latency", 64'(w <= 1), 64'd1);
    exp_count++;
    check_idle("uc_wr");

    for (int i = 0; i < 40; i++) begin
      rt = 4'($urandom_range(0, 3));
      do_txn(rt, LI'($urandom), PA'({$urandom, $urandom}), 3'($urandom), 1'($urandom),
             WW'($urandom), $urandom_range(0, 3), "rand");
    end

    // bad acks in e_ack: each flags an error and leaves the FSM waiting
    send_req(e_bedrock_req_rd_miss, 4'd5, 40'h00_0000_1000, 3'd0, 1'b1, 2'd2, 64'd0);
    expect_cmd(e_bedrock_req_rd_miss, 4'd5, 40'h00_0000_1000, 3'd0, 1'b1, 2'd2, 0, w);
    send_resp(e_bedrock_resp_coh_ack, 4'd5, 40'h00_0000_1040);
    exp_error = 1'b1;
    @(negedge clk);
    check("bad_addr_error", 64'(error), 64'd1);
    check("bad_addr_not_ready", 64'(lce_req_ready_then), 64'd0);
    check("bad_addr_count", 64'(txn_count), 64'(exp_count));
    send_resp(e_bedrock_resp_coh_ack, 4'd6, 40'h00_0000_1000);
    send_resp(RESP_INV_ACK, 4'd5, 40'h00_0000_1000);
    @(negedge clk);
    check("bad_ack_not_ready", 64'(lce_req_ready_then), 64'd0);
    send_resp(e_bedrock_resp_coh_ack, 4'd5, 40'h00_0000_1000);
    exp_count++;
    check_idle("good_ack_after_bad");

    // reset pulsed while a command is pending
    send_req(e_bedrock_req_uc_rd, 4'd3, 40'h00_0000_2000, 3'd1, 1'b0, 2'd0, 64'd0);
    @(negedge clk);
    check("pre_reset_cmd_v", 64'(lce_cmd_v), 64'd1);
    #2 reset_n = 1'b0;
    #1 begin
      check("async_rst_cmd_v", 64'(lce_cmd_v), 64'd0);
      check("async_rst_count", 64'(txn_count), 64'd0);
      check("async_rst_error", 64'(error), 64'd0);
      check("async_rst_ready", 64'(lce_req_ready_then), 64'd0);
    end
    exp_count = 0;
    exp_error = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1 check("post_rst_ready", 64'(lce_req_ready_then), 64'd1);
    check_idle("post_rst");

    // undefined request type: error, no command
    send_req(4'd9, 4'd1, 40'h00_0000_3000, 3'd0, 1'b0, 2'd0, 64'd0);
    exp_error = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("undef_no_cmd", 64'(lce_cmd_v), 64'd0);
    end
    check_idle("undef");

    // counter wrap
    for (int i = 0; i < (1 << CNT_W) - 1; i++)
      do_txn(e_bedrock_req_uc_rd, LI'($urandom), PA'({$urandom, $urandom}), 3'($urandom), 1'b0,
             WW'($urandom), 0, "preload");
    check("count_all_ones", 64'(txn_count), 64'((1 << CNT_W) - 1));
    do_txn(e_bedrock_req_uc_rd, 4'd7, 40'h00_0000_4000, 3'd3, 1'b0, 2'd1, 0, "wrap");
    check("count_wrapped", 64'(txn_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
